ysyx_22050058_div: RTL and testbench

Multi-cycle integer divider for the EX stage of the ysyx_22050058 core. It executes RV64M DIV/DIVU/REM/REMU and the word variants DIVW/DIVUW/REMW/REMUW using a radix-2 restoring algorithm that produces one quotient bit per cycle. While a division is in flight it drives the EX stall request into the pipeline controller, and it aborts on an EX flush.

---
 rtl/ysyx_22050058_div.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_22050058_div.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050058_div.sv
// ysyx_22050058_div
//   Multi-cycle radix-2 restoring divider for the EX stage. Handles
//   DIV/DIVU/REM/REMU and the 32-bit W variants, one quotient bit per cycle.
//   Divide-by-zero and signed overflow finish in a single cycle.
//
// Ports
//   clk              core clock, rising edge
//   rst              synchronous active-high reset
//   div_start_i      EX holds a divide op (held for the life of the op)
//   div_signed_i     1: DIV/REM semantics, 0: DIVU/REMU semantics
//   div_word_i       1: 32-bit op (W variants)
//   div_dividend_i   rs1
//   div_divisor_i    rs2
//   div_cancel_i     abort from EX flush, priority over start
//   div_quotient_o   registered quotient, held between ops
//   div_remainder_o  registered remainder, held between ops
//   div_ready_o      one-cycle result-valid pulse (DONE state)
//   div_stall_req_o  EX stall request to the pipeline controller
//
// state | meaning
// IDLE  | waiting for start; accepts and decodes the op
// CALC  | one restoring step per cycle, counter counts N down to 1
// DONE  | results valid, ready pulse, always returns to IDLE
module ysyx_22050058_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start_i,
  input  logic            div_signed_i,
  input  logic            div_word_i,
  input  logic [XLEN-1:0] div_dividend_i,
  input  logic [XLEN-1:0] div_divisor_i,
  input  logic            div_cancel_i,
  output logic [XLEN-1:0] div_quotient_o,
  output logic [XLEN-1:0] div_remainder_o,
  output logic            div_ready_o,
  output logic            div_stall_req_o
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;   // partial remainder
  logic [XLEN-1:0] dvd_q, dvd_d;   // dividend shifter, fills with quotient bits
  logic [XLEN-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rmd_q, rmd_d;
  logic            ready_q, ready_d;
  logic            word_q, word_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  // Word results are always sign-extended from bit 31, even for DIVUW/REMUW.
  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
    return w ? {{HALF{x[HALF-1]}}, x[HALF-1:0]} : x;
  endfunction

  // Operand decode at the accept edge
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic            a_neg, b_neg, div_zero, ovf;

  always_comb begin
    a_ext = div_dividend_i;
    b_ext = div_divisor_i;
    if (div_word_i) begin
      a_ext = {{HALF{div_signed_i & div_dividend_i[HALF-1]}}, div_dividend_i[HALF-1:0]};
      b_ext = {{HALF{div_signed_i & div_divisor_i[HALF-1]}}, div_divisor_i[HALF-1:0]};
    end
    a_neg    = div_signed_i & a_ext[XLEN-1];
    b_neg    = div_signed_i & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    // Most-negative / -1: in word mode the 32-bit compare is done on the sign-extended value
    ovf      = div_signed_i & (b_ext == '1) &
               (div_word_i ? (a_ext == {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}})
                           : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
  end

  // One restoring step. sh is XLEN+1 bits because the shifted remainder can
  // exceed XLEN bits when the divisor is large.
  logic [XLEN:0]   sh;
  logic            ge;
  logic [XLEN-1:0] rem_nx, dvd_nx, q_mag, q_sgn, r_sgn;

  always_comb begin
    sh     = {rem_q, dvd_q[XLEN-1]};
    ge     = (sh >= {1'b0, dvs_q});
    rem_nx = ge ? (sh[XLEN-1:0] - dvs_q) : sh[XLEN-1:0];
    dvd_nx = {dvd_q[XLEN-2:0], ge};
    q_mag  = word_q ? {{HALF{1'b0}}, dvd_nx[HALF-1:0]} : dvd_nx;
    q_sgn  = negq_q ? -q_mag : q_mag;
    r_sgn  = negr_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ready_d = 1'b0;
    word_d  = word_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    case (state_q)
      IDLE: begin
        if (div_start_i) begin
          word_d = div_word_i;
          if (div_zero) begin
            quo_d   = '1;
            rmd_d   = wfix(div_word_i, div_dividend_i);
            ready_d = 1'b1;
            state_d = DONE;
          end else if (ovf) begin
            quo_d   = wfix(div_word_i, div_dividend_i);
            rmd_d   = '0;
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            // Word magnitudes fit in HALF bits; park them in the top half so
            // HALF shifts bring every bit through the remainder.
            dvd_d   = div_word_i ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            cnt_d   = div_word_i ? CW'(HALF) : CW'(XLEN);
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quo_d   = wfix(word_q, q_sgn);
          rmd_d   = wfix(word_q, r_sgn);
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flush wins over everything: no result write, no ready pulse.
    if (div_cancel_i) begin
      state_d = IDLE;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      ready_q <= 1'b0;
      word_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      ready_q <= ready_d;
      word_q  <= word_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign div_quotient_o  = quo_q;
  assign div_remainder_o = rmd_q;
  assign div_ready_o     = ready_q;
  assign div_stall_req_o = ~rst & (((state_q == IDLE) & div_start_i & ~div_cancel_i) |
                                   (state_q == CALC));

endmodule

// File: tb/tb_ysyx_22050058_div.sv
// Testbench for ysyx_22050058_div: directed test-plan ops plus randomized ops
// checked against an arithmetic reference model, with a per-cycle compare of
// ready, stall and the held result registers.
module tb_ysyx_22050058_div;

  logic        clk;
  logic        rst;
  logic        div_start_i;
  logic        div_signed_i;
  logic        div_word_i;
  logic [63:0] div_dividend_i;
  logic [63:0] div_divisor_i;
  logic        div_cancel_i;
  logic [63:0] div_quotient_o;
  logic [63:0] div_remainder_o;
  logic        div_ready_o;
  logic        div_stall_req_o;

  ysyx_22050058_div #(.XLEN(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .div_start_i     (div_start_i),
    .div_signed_i    (div_signed_i),
    .div_word_i      (div_word_i),
    .div_dividend_i  (div_dividend_i),
    .div_divisor_i   (div_divisor_i),
    .div_cancel_i    (div_cancel_i),
    .div_quotient_o  (div_quotient_o),
    .div_remainder_o (div_remainder_o),
    .div_ready_o     (div_ready_o),
    .div_stall_req_o (div_stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  logic        exp_ready, exp_stall;
  logic [63:0] exp_q, exp_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: RISC-V divide semantics with plain arithmetic.
  function automatic void model(input bit s, input bit w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q,
                                output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    int          sa, sb;
    longint      la, lb;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (s) begin
        sa = a32; sb = b32;
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0;
      end else if (s) begin
        la = a; lb = b;
        q = la / lb; r = la % lb;
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  function automatic bit is_special(input bit s, input bit w, input logic [63:0] a,
                                    input logic [63:0] b);
    if (w) return (b[31:0] == 32'd0) ||
                  (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {63'd0, div_ready_o}, {63'd0, exp_ready});
      chk("stall", {63'd0, div_stall_req_o}, {63'd0, exp_stall});
      chk("quotient", div_quotient_o, exp_q);
      chk("remainder", div_remainder_o, exp_r);
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; div_cancel_i = 1'b0; div_start_i = 1'b0;
      exp_stall = 1'b0; exp_ready = 1'b0;
    end
  endtask

  // Cycle 0 is the accept cycle; DONE is cycle lat. abort_at >= 1 pulses
  // cancel (or rst) in that cycle and the op is dropped.
  task automatic run_op(input bit s, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input int abort_at, input bit use_rst);
    logic [63:0] mq, mr;
    int          lat;
    model(s, w, a, b, mq, mr);
    lat = is_special(s, w, a, b) ? 1 : (w ? 33 : 65);
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; div_cancel_i = 1'b0; div_start_i = 1'b1;
      if (k == 0) begin
        div_signed_i = s; div_word_i = w; div_dividend_i = a; div_divisor_i = b;
      end else begin
        div_signed_i   = 1'($urandom_range(0, 1));
        div_word_i     = 1'($urandom_range(0, 1));
        div_dividend_i = {$urandom, $urandom};
        div_divisor_i  = {$urandom, $urandom};
      end
      exp_ready = (k == lat);
      exp_stall = (k < lat);
      if (k == lat) begin
        exp_q = mq; exp_r = mr;
      end
      if (k == abort_at) begin
        if (use_rst) rst = 1'b1; else div_cancel_i = 1'b1;
        exp_stall = !use_rst;
        exp_ready = 1'b0;
        @(negedge clk); #1;
        if (use_rst) begin
          exp_q = 64'd0; exp_r = 64'd0;
        end
        return;
      end
    end
  endtask

  logic [63:0] pq, pr;

  initial begin
    rst = 1'b1; div_start_i = 1'b1; div_cancel_i = 1'b0;
    div_signed_i = 1'b0; div_word_i = 1'b0;
    div_dividend_i = 64'd5; div_divisor_i = 64'd3;
    exp_ready = 1'b0; exp_stall = 1'b0; exp_q = 64'd0; exp_r = 64'd0;

    // Pin the model on hand-computed values.
    model(1, 0, 64'd100, 64'd7, pq, pr);
    chk("pin_div_q", pq, 64'd14);
    chk("pin_div_r", pr, 64'd2);
    model(1, 0, -64'sd7, 64'd2, pq, pr);
    chk("pin_neg_q", pq, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_neg_r", pr, 64'hFFFF_FFFF_FFFF_FFFF);
    model(0, 0, 64'h1234, 64'd0, pq, pr);
    chk("pin_dz_q", pq, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_dz_r", pr, 64'h1234);
    model(1, 0, 64'h8000_0000_0000_0000, '1, pq, pr);
    chk("pin_ovf_q", pq, 64'h8000_0000_0000_0000);
    chk("pin_ovf_r", pr, 64'd0);
    model(1, 1, 64'h8000_0000, 64'hFFFF_FFFF, pq, pr);
    chk("pin_ovfw_q", pq, 64'hFFFF_FFFF_8000_0000);
    model(0, 1, 64'hFFFF_FFFF, 64'd1, pq, pr);
    chk("pin_divuw_q", pq, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_divuw_r", pr, 64'd0);

    // Reset with start asserted: stall must stay low, outputs zero.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Directed test-plan ops
    run_op(1, 0, 64'd100, 64'd7, -1, 0);
    idle(1);
    run_op(1, 0, -64'sd7, 64'd2, -1, 0);
    run_op(0, 0, 64'h1234, 64'd0, -1, 0);
    run_op(1, 0, 64'h8000_0000_0000_0000, '1, -1, 0);
    run_op(1, 1, 64'h8000_0000, 64'hFFFF_FFFF, -1, 0);
    run_op(0, 1, 64'hFFFF_FFFF, 64'd1, -1, 0);
    idle(2);

    // Cancel at cycle 10, fresh start at cycle 11 completes at 76.
    run_op(1, 0, 64'd999, 64'd10, 10, 0);
    run_op(0, 0, 64'hDEAD_BEEF_0000_0001, 64'd3, -1, 0);
    // Cancel in the final CALC cycle: no result write.
    run_op(0, 0, 64'd77, 64'd5, 64, 0);
    idle(1);
    // Cancel together with start in IDLE: never accepted.
    @(posedge clk); #1;
    div_start_i = 1'b1; div_cancel_i = 1'b1; div_divisor_i = 64'd0;
    exp_stall = 1'b0; exp_ready = 1'b0;
    idle(2);
    // Reset mid-op: outputs return to zero.
    run_op(1, 0, 64'd500, 64'd9, 10, 1);
    idle(3);

    // Randomized ops
    for (int i = 0; i < 300; i++) begin
      bit          s, w, ur;
      int          cls, ab;
      logic [63:0] a, b;
      s   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      cls = $urandom_range(0, 7);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      ab  = -1;
      ur  = 1'($urandom_range(0, 1));
      case (cls)
        0: b = w ? {b[63:32], 32'd0} : 64'd0;
        1: begin
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
        end
        2: begin
          b = 64'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: a = 64'($urandom_range(0, 100));
        7: ab = $urandom_range(1, 30);
        default: ;
      endcase
      run_op(s, w, a, b, ab, ur);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
